// File: rtl/hyperbus_axi_rr_frontend.sv
// AXI4 slave front-end for the HyperBus PHY: one transaction in flight, round-robin
// read/write arbitration, address-window chip-select decode and complete error responses.
module hyperbus_axi_rr_frontend #(
    parameter int NR_CS       = 2,
    parameter int BURST_WIDTH = 12,
    parameter int AXI_IW      = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [64*NR_CS-1:0]    addr_map_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [31:0]            aw_addr_i,
    input  logic [7:0]             aw_len_i,
    input  logic [1:0]             aw_burst_i,
    input  logic [AXI_IW-1:0]      aw_id_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [15:0]            w_data_i,
    input  logic [1:0]             w_strb_i,
    input  logic                   w_last_i,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [1:0]             b_resp_o,
    output logic [AXI_IW-1:0]      b_id_o,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    input  logic [31:0]            ar_addr_i,
    input  logic [7:0]             ar_len_i,
    input  logic [1:0]             ar_burst_i,
    input  logic [AXI_IW-1:0]      ar_id_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [15:0]            r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   r_last_o,
    output logic [AXI_IW-1:0]      r_id_o,
    input  logic [15:0]            rx_data_i,
    input  logic                   rx_last_i,
    input  logic                   rx_error_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic [15:0]            tx_data_o,
    output logic [1:0]             tx_strb_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    input  logic                   phy_b_valid_i,
    input  logic                   phy_b_last_i,
    input  logic                   phy_b_error_i,
    output logic                   phy_b_ready_o,
    output logic                   trans_valid_o,
    input  logic                   trans_ready_i,
    output logic [31:0]            trans_address_o,
    output logic [NR_CS-1:0]       trans_cs_o,
    output logic                   trans_write_o,
    output logic [BURST_WIDTH-1:0] trans_burst_o,
    output logic                   trans_burst_type_o,
    output logic                   trans_address_space_o
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_RESP, ERR_RD, ERR_WR
    } state_e;

    state_e                 state_q, state_d;
    logic                   rr_last_write_q, rr_last_write_d;
    logic [AXI_IW-1:0]      id_q, id_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   r_err_q, r_err_d;
    logic                   b_err_q, b_err_d;
    logic                   b_valid_q, b_valid_d;
    logic [1:0]             b_resp_q, b_resp_d;
    logic                   trans_valid_q, trans_valid_d;
    logic [31:0]            trans_address_q, trans_address_d;
    logic [NR_CS-1:0]       trans_cs_q, trans_cs_d;
    logic                   trans_write_q, trans_write_d;
    logic [BURST_WIDTH-1:0] trans_burst_q, trans_burst_d;
    logic                   trans_burst_type_q, trans_burst_type_d;
    logic                   trans_address_space_q, trans_address_space_d;

    logic                   grant_rd, grant_wr;
    logic [31:0]            req_addr;
    logic [7:0]             req_len;
    logic [1:0]             req_burst;
    logic [AXI_IW-1:0]      req_id;
    logic [NR_CS-1:0]       dec_cs;
    logic                   dec_hit;
    logic                   cnt_zero;
    logic                   unused_bits;

    // On a tie the channel that did not win last time gets the grant.
    assign grant_rd  = ar_valid_i && (!aw_valid_i || rr_last_write_q);
    assign grant_wr  = aw_valid_i && !grant_rd;
    assign req_addr  = grant_rd ? ar_addr_i  : aw_addr_i;
    assign req_len   = grant_rd ? ar_len_i   : aw_len_i;
    assign req_burst = grant_rd ? ar_burst_i : aw_burst_i;
    assign req_id    = grant_rd ? ar_id_i    : aw_id_i;
    assign cnt_zero  = (cnt_q == 8'd0);
    assign unused_bits = ^{addr_map_i, req_burst[1]};

    always_comb begin
        dec_cs  = '0;
        dec_hit = 1'b0;
        for (int i = 0; i < NR_CS; i++) begin
            if (!dec_hit && req_addr[30:0] >= addr_map_i[64*i +: 31]
                         && req_addr[30:0] <= addr_map_i[64*i+32 +: 31]) begin
                dec_cs[i] = 1'b1;
                dec_hit   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d               = state_q;
        rr_last_write_d       = rr_last_write_q;
        id_d                  = id_q;
        cnt_d                 = cnt_q;
        r_err_d               = r_err_q;
        b_err_d               = b_err_q;
        b_valid_d             = b_valid_q;
        b_resp_d              = b_resp_q;
        trans_valid_d         = trans_valid_q;
        trans_address_d       = trans_address_q;
        trans_cs_d            = trans_cs_q;
        trans_write_d         = trans_write_q;
        trans_burst_d         = trans_burst_q;
        trans_burst_type_d    = trans_burst_type_q;
        trans_address_space_d = trans_address_space_q;
        unique case (state_q)
            IDLE: begin
                if (grant_rd || grant_wr) begin
                    rr_last_write_d = grant_wr;
                    id_d            = req_id;
                    cnt_d           = req_len;
                    r_err_d         = 1'b0;
                    b_err_d         = 1'b0;
                    b_resp_d        = 2'b00;
                    if (!dec_hit) begin
                        state_d = grant_rd ? ERR_RD : ERR_WR;
                    end else begin
                        state_d               = grant_rd ? RD_REQ : WR_REQ;
                        trans_valid_d         = 1'b1;
                        trans_address_d       = req_addr;
                        trans_cs_d            = dec_cs;
                        trans_write_d         = grant_wr;
                        trans_burst_d         = BURST_WIDTH'({1'b0, req_len} + 9'd1);
                        trans_burst_type_d    = req_burst[0];
                        trans_address_space_d = req_addr[31];
                    end
                end
            end
            RD_REQ, WR_REQ: begin
                if (trans_ready_i) begin
                    trans_valid_d = 1'b0;
                    state_d       = (state_q == RD_REQ) ? RD_DATA : WR_DATA;
                end
            end
            RD_DATA: begin
                if (rx_valid_i && r_ready_i) begin
                    if (rx_error_i) r_err_d = 1'b1;
                    if (rx_last_i || cnt_zero) state_d = IDLE;
                    else cnt_d = cnt_q - 8'd1;
                end
            end
            ERR_RD: begin
                if (r_ready_i) begin
                    if (cnt_zero) state_d = IDLE;
                    else cnt_d = cnt_q - 8'd1;
                end
            end
            WR_DATA: begin
                if (phy_b_valid_i && phy_b_error_i) b_err_d = 1'b1;
                if (w_valid_i && tx_ready_i && w_last_i) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (phy_b_valid_i && phy_b_error_i) b_err_d = 1'b1;
                if (!b_valid_q && phy_b_valid_i && phy_b_last_i) begin
                    b_valid_d = 1'b1;
                    b_resp_d  = (b_err_q || phy_b_error_i) ? 2'b10 : 2'b00;
                end else if (b_valid_q && b_ready_i) begin
                    b_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            ERR_WR: begin
                if (!b_valid_q && w_valid_i && w_last_i) begin
                    b_valid_d = 1'b1;
                    b_resp_d  = 2'b11;
                end else if (b_valid_q && b_ready_i) begin
                    b_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q               <= IDLE;
            rr_last_write_q       <= 1'b1;
            id_q                  <= '0;
            cnt_q                 <= '0;
            r_err_q               <= 1'b0;
            b_err_q               <= 1'b0;
            b_valid_q             <= 1'b0;
            b_resp_q              <= 2'b00;
            trans_valid_q         <= 1'b0;
            trans_address_q       <= '0;
            trans_cs_q            <= '0;
            trans_write_q         <= 1'b0;
            trans_burst_q         <= '0;
            trans_burst_type_q    <= 1'b0;
            trans_address_space_q <= 1'b0;
        end else begin
            state_q               <= state_d;
            rr_last_write_q       <= rr_last_write_d;
            id_q                  <= id_d;
            cnt_q                 <= cnt_d;
            r_err_q               <= r_err_d;
            b_err_q               <= b_err_d;
            b_valid_q             <= b_valid_d;
            b_resp_q              <= b_resp_d;
            trans_valid_q         <= trans_valid_d;
            trans_address_q       <= trans_address_d;
            trans_cs_q            <= trans_cs_d;
            trans_write_q         <= trans_write_d;
            trans_burst_q         <= trans_burst_d;
            trans_burst_type_q    <= trans_burst_type_d;
            trans_address_space_q <= trans_address_space_d;
        end
    end

    // Data paths are forwarded combinationally so the front-end adds no latency.
    always_comb begin
        ar_ready_o    = rst_ni && (state_q == IDLE) && grant_rd;
        aw_ready_o    = rst_ni && (state_q == IDLE) && grant_wr;
        r_valid_o     = 1'b0;
        r_data_o      = '0;
        r_resp_o      = 2'b00;
        r_last_o      = 1'b0;
        rx_ready_o    = 1'b0;
        tx_valid_o    = 1'b0;
        tx_data_o     = '0;
        tx_strb_o     = '0;
        w_ready_o     = 1'b0;
        phy_b_ready_o = 1'b0;
        unique case (state_q)
            RD_DATA: begin
                r_valid_o  = rx_valid_i;
                rx_ready_o = r_ready_i;
                r_data_o   = rx_data_i;
                r_last_o   = rx_last_i || cnt_zero;
                r_resp_o   = (r_err_q || rx_error_i) ? 2'b10 : 2'b00;
            end
            ERR_RD: begin
                r_valid_o = 1'b1;
                r_resp_o  = 2'b11;
                r_last_o  = cnt_zero;
            end
            WR_DATA: begin
                tx_valid_o = w_valid_i;
                w_ready_o  = tx_ready_i;
                tx_data_o  = w_data_i;
                tx_strb_o  = ~w_strb_i;
            end
            WR_RESP: phy_b_ready_o = !b_valid_q;
            ERR_WR:  w_ready_o     = !b_valid_q;
            default: ;
        endcase
    end

    assign r_id_o                = id_q;
    assign b_id_o                = id_q;
    assign b_valid_o             = b_valid_q;
    assign b_resp_o              = b_resp_q;
    assign trans_valid_o         = trans_valid_q;
    assign trans_address_o       = trans_address_q;
    assign trans_cs_o            = trans_cs_q;
    assign trans_write_o         = trans_write_q;
    assign trans_burst_o         = trans_burst_q;
    assign trans_burst_type_o    = trans_burst_type_q;
    assign trans_address_space_o = trans_address_space_q;

endmodule

// File: tb/tb_hyperbus_axi_rr_frontend.sv
// Directed bench for hyperbus_axi_rr_frontend with four chip-select windows,
// windows 1 and 3 overlapping. Inputs change at the falling edge, outputs are checked 1ns later.
module tb_hyperbus_axi_rr_frontend;

    localparam int NR_CS       = 4;
    localparam int BURST_WIDTH = 12;
    localparam int AXI_IW      = 10;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [64*NR_CS-1:0]    addr_map_i;
    logic                   aw_valid_i, aw_ready_o;
    logic [31:0]            aw_addr_i;
    logic [7:0]             aw_len_i;
    logic [1:0]             aw_burst_i;
    logic [AXI_IW-1:0]      aw_id_i;
    logic                   w_valid_i, w_ready_o;
    logic [15:0]            w_data_i;
    logic [1:0]             w_strb_i;
    logic                   w_last_i;
    logic                   b_valid_o, b_ready_i;
    logic [1:0]             b_resp_o;
    logic [AXI_IW-1:0]      b_id_o;
    logic                   ar_valid_i, ar_ready_o;
    logic [31:0]            ar_addr_i;
    logic [7:0]             ar_len_i;
    logic [1:0]             ar_burst_i;
    logic [AXI_IW-1:0]      ar_id_i;
    logic                   r_valid_o, r_ready_i;
    logic [15:0]            r_data_o;
    logic [1:0]             r_resp_o;
    logic                   r_last_o;
    logic [AXI_IW-1:0]      r_id_o;
    logic [15:0]            rx_data_i;
    logic                   rx_last_i, rx_error_i, rx_valid_i, rx_ready_o;
    logic [15:0]            tx_data_o;
    logic [1:0]             tx_strb_o;
    logic                   tx_valid_o, tx_ready_i;
    logic                   phy_b_valid_i, phy_b_last_i, phy_b_error_i, phy_b_ready_o;
    logic                   trans_valid_o, trans_ready_i;
    logic [31:0]            trans_address_o;
    logic [NR_CS-1:0]       trans_cs_o;
    logic                   trans_write_o;
    logic [BURST_WIDTH-1:0] trans_burst_o;
    logic                   trans_burst_type_o, trans_address_space_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk_i = ~clk_i;

    hyperbus_axi_rr_frontend #(.NR_CS(NR_CS), .BURST_WIDTH(BURST_WIDTH), .AXI_IW(AXI_IW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .addr_map_i(addr_map_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
        .aw_len_i(aw_len_i), .aw_burst_i(aw_burst_i), .aw_id_i(aw_id_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .w_strb_i(w_strb_i), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_resp_o(b_resp_o), .b_id_o(b_id_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i), .ar_burst_i(ar_burst_i), .ar_id_i(ar_id_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o), .r_id_o(r_id_o),
        .rx_data_i(rx_data_i), .rx_last_i(rx_last_i), .rx_error_i(rx_error_i),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_strb_o(tx_strb_o), .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i),
        .phy_b_valid_i(phy_b_valid_i), .phy_b_last_i(phy_b_last_i),
        .phy_b_error_i(phy_b_error_i), .phy_b_ready_o(phy_b_ready_o),
        .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i),
        .trans_address_o(trans_address_o), .trans_cs_o(trans_cs_o),
        .trans_write_o(trans_write_o), .trans_burst_o(trans_burst_o),
        .trans_burst_type_o(trans_burst_type_o), .trans_address_space_o(trans_address_space_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Moves to the next falling edge, where the caller drives the next set of inputs.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk_i);
    endtask

    initial begin
        rst_ni = 1'b0;
        // {end, start} per window; window 3 overlaps the top half of window 1.
        addr_map_i = {32'h0002_FFFF, 32'h0001_8000, 32'h0004_FFFF, 32'h0004_0000,
                      32'h0001_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_0000};
        aw_valid_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_burst_i = 0; aw_id_i = 0;
        w_valid_i = 0; w_data_i = 0; w_strb_i = 0; w_last_i = 0; b_ready_i = 0;
        ar_valid_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_burst_i = 0; ar_id_i = 0;
        r_ready_i = 0; rx_data_i = 0; rx_last_i = 0; rx_error_i = 0; rx_valid_i = 0;
        tx_ready_i = 0; phy_b_valid_i = 0; phy_b_last_i = 0; phy_b_error_i = 0;
        trans_ready_i = 0;

        applyStimulus(2); #1;
        checkOutput("rst_trans_valid", trans_valid_o, 0);
        checkOutput("rst_trans_cs", trans_cs_o, 0);
        checkOutput("rst_b_valid", b_valid_o, 0);
        checkOutput("rst_r_valid", r_valid_o, 0);

        // Mapped read, len 3, r_last from the beat counter alone
        applyStimulus(1);
        rst_ni = 1; ar_valid_i = 1; ar_addr_i = 32'h100; ar_len_i = 3; ar_burst_i = 2'b01; ar_id_i = 5;
        #1;
        checkOutput("t1_ar_ready", ar_ready_o, 1);
        checkOutput("t1_trans_valid_early", trans_valid_o, 0);
        applyStimulus(1); ar_valid_i = 0; #1;
        checkOutput("t1_trans_valid", trans_valid_o, 1);
        checkOutput("t1_trans_cs", trans_cs_o, 4'b0001);
        checkOutput("t1_trans_burst", trans_burst_o, 4);
        checkOutput("t1_trans_write", trans_write_o, 0);
        checkOutput("t1_trans_btype", trans_burst_type_o, 1);
        checkOutput("t1_trans_addr", trans_address_o, 32'h100);
        trans_ready_i = 1;
        applyStimulus(1); trans_ready_i = 0; r_ready_i = 1; rx_valid_i = 1;
        #1;
        checkOutput("t1_trans_valid_drop", trans_valid_o, 0);
        for (int k = 0; k < 4; k++) begin
            rx_data_i = 16'hA000 + 16'(k); #1;
            checkOutput("t1_r_valid", r_valid_o, 1);
            checkOutput("t1_r_data", r_data_o, 16'hA000 + 16'(k));
            checkOutput("t1_r_id", r_id_o, 5);
            checkOutput("t1_r_resp", r_resp_o, 0);
            checkOutput("t1_r_last", r_last_o, (k == 3) ? 1 : 0);
            applyStimulus(1);
        end
        #1;
        checkOutput("t1_r_valid_after", r_valid_o, 0);
        rx_valid_i = 0; r_ready_i = 0;

        // Round-robin: tie after reset goes to read, the next tie to write
        rst_ni = 0;
        applyStimulus(1);
        rst_ni = 1;
        ar_valid_i = 1; ar_addr_i = 32'h200; ar_len_i = 0; ar_id_i = 1;
        aw_valid_i = 1; aw_addr_i = 32'h300; aw_len_i = 0; aw_burst_i = 2'b01; aw_id_i = 2;
        #1;
        checkOutput("t2_ar_ready_tie", ar_ready_o, 1);
        checkOutput("t2_aw_ready_tie", aw_ready_o, 0);
        applyStimulus(1); ar_valid_i = 0; trans_ready_i = 1; #1;
        checkOutput("t2_aw_ready_busy", aw_ready_o, 0);
        applyStimulus(1); trans_ready_i = 0; rx_valid_i = 1; r_ready_i = 1; rx_last_i = 1; rx_data_i = 16'h1234;
        #1;
        checkOutput("t2_r_last", r_last_o, 1);
        checkOutput("t2_r_id", r_id_o, 1);
        applyStimulus(1); rx_valid_i = 0; r_ready_i = 0; rx_last_i = 0;
        ar_valid_i = 1; ar_addr_i = 32'h400; ar_len_i = 0; ar_id_i = 3;
        #1;
        checkOutput("t2_aw_ready_second", aw_ready_o, 1);
        checkOutput("t2_ar_ready_second", ar_ready_o, 0);
        applyStimulus(1); aw_valid_i = 0; #1;
        checkOutput("t2_trans_write", trans_write_o, 1);
        checkOutput("t2_trans_addr", trans_address_o, 32'h300);
        checkOutput("t2_ar_ready_wr", ar_ready_o, 0);
        trans_ready_i = 1;
        applyStimulus(1); trans_ready_i = 0;
        w_valid_i = 1; w_data_i = 16'hBEEF; w_strb_i = 2'b01; w_last_i = 1; tx_ready_i = 1;
        #1;
        checkOutput("t2_tx_valid", tx_valid_o, 1);
        checkOutput("t2_tx_data", tx_data_o, 16'hBEEF);
        checkOutput("t2_tx_strb", tx_strb_o, 2'b10);
        checkOutput("t2_w_ready", w_ready_o, 1);
        applyStimulus(1); w_valid_i = 0; w_last_i = 0;
        phy_b_valid_i = 1; phy_b_last_i = 1; phy_b_error_i = 0;
        #1;
        checkOutput("t2_phy_b_ready", phy_b_ready_o, 1);
        checkOutput("t2_b_valid_early", b_valid_o, 0);
        applyStimulus(1); phy_b_valid_i = 0; phy_b_last_i = 0; #1;
        checkOutput("t2_b_valid", b_valid_o, 1);
        checkOutput("t2_b_resp", b_resp_o, 2'b00);
        checkOutput("t2_b_id", b_id_o, 2);
        b_ready_i = 1;
        applyStimulus(1); b_ready_i = 0; #1;
        checkOutput("t2_ar_ready_after_wr", ar_ready_o, 1);
        applyStimulus(1); ar_valid_i = 0; trans_ready_i = 1;
        applyStimulus(1); trans_ready_i = 0; rx_valid_i = 1; r_ready_i = 1; rx_last_i = 1; rx_data_i = 16'h5555;
        #1;
        checkOutput("t2_r_id_second", r_id_o, 3);
        applyStimulus(1); rx_valid_i = 0; r_ready_i = 0; rx_last_i = 0;

        // Unmapped write, len 1: W drained, B resp 11
        aw_valid_i = 1; aw_addr_i = 32'h0010_0000; aw_len_i = 1; aw_id_i = 7;
        #1;
        checkOutput("t3_aw_ready", aw_ready_o, 1);
        applyStimulus(1); aw_valid_i = 0; w_valid_i = 1; w_last_i = 0; w_data_i = 16'h0F0F; #1;
        checkOutput("t3_trans_valid", trans_valid_o, 0);
        checkOutput("t3_w_ready_b1", w_ready_o, 1);
        checkOutput("t3_tx_valid_b1", tx_valid_o, 0);
        applyStimulus(1); w_last_i = 1; #1;
        checkOutput("t3_w_ready_b2", w_ready_o, 1);
        checkOutput("t3_tx_valid_b2", tx_valid_o, 0);
        checkOutput("t3_b_valid_early", b_valid_o, 0);
        applyStimulus(1); w_valid_i = 0; w_last_i = 0; #1;
        checkOutput("t3_b_valid", b_valid_o, 1);
        checkOutput("t3_b_resp", b_resp_o, 2'b11);
        checkOutput("t3_b_id", b_id_o, 7);
        b_ready_i = 1;
        applyStimulus(1); b_ready_i = 0;

        // Unmapped read, len 7: eight zero beats with resp 11
        ar_valid_i = 1; ar_addr_i = 32'h0010_0000; ar_len_i = 7; ar_id_i = 9;
        #1;
        checkOutput("t4_ar_ready", ar_ready_o, 1);
        applyStimulus(1); ar_valid_i = 0; r_ready_i = 1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput("t4_r_valid", r_valid_o, 1);
            checkOutput("t4_r_data", r_data_o, 0);
            checkOutput("t4_r_resp", r_resp_o, 2'b11);
            checkOutput("t4_r_last", r_last_o, (k == 7) ? 1 : 0);
            checkOutput("t4_rx_ready", rx_ready_o, 0);
            checkOutput("t4_trans_valid", trans_valid_o, 0);
            applyStimulus(1);
        end
        #1;
        checkOutput("t4_r_valid_after", r_valid_o, 0);
        r_ready_i = 0;

        // Write len 2 with PHY error on the first response beat
        aw_valid_i = 1; aw_addr_i = 32'h10; aw_len_i = 2; aw_burst_i = 2'b01; aw_id_i = 4;
        #1;
        checkOutput("t5_aw_ready", aw_ready_o, 1);
        applyStimulus(1); aw_valid_i = 0; trans_ready_i = 1; #1;
        checkOutput("t5_trans_burst", trans_burst_o, 3);
        applyStimulus(1); trans_ready_i = 0; w_valid_i = 1; tx_ready_i = 1; w_strb_i = 2'b11;
        for (int k = 0; k < 3; k++) begin
            w_last_i = (k == 2); w_data_i = 16'h1000 + 16'(k); #1;
            checkOutput("t5_tx_data", tx_data_o, 16'h1000 + 16'(k));
            applyStimulus(1);
        end
        w_valid_i = 0; w_last_i = 0;
        phy_b_valid_i = 1; phy_b_error_i = 1; phy_b_last_i = 0; #1;
        checkOutput("t5_phy_b_ready_1", phy_b_ready_o, 1);
        applyStimulus(1); phy_b_error_i = 0; phy_b_last_i = 1; #1;
        checkOutput("t5_b_valid_early", b_valid_o, 0);
        checkOutput("t5_phy_b_ready_2", phy_b_ready_o, 1);
        applyStimulus(1); phy_b_valid_i = 0; phy_b_last_i = 0; #1;
        checkOutput("t5_b_valid", b_valid_o, 1);
        checkOutput("t5_b_resp", b_resp_o, 2'b10);
        checkOutput("t5_b_id", b_id_o, 4);
        b_ready_i = 1;
        applyStimulus(1); b_ready_i = 0;

        // Read len 2 with rx_error on beat 2: beats 2 and 3 report 10
        ar_valid_i = 1; ar_addr_i = 32'h20; ar_len_i = 2; ar_id_i = 6;
        applyStimulus(1); ar_valid_i = 0; trans_ready_i = 1;
        applyStimulus(1); trans_ready_i = 0; rx_valid_i = 1; r_ready_i = 1;
        for (int k = 0; k < 3; k++) begin
            rx_error_i = (k == 1); rx_last_i = (k == 2); #1;
            checkOutput("t5_r_resp", r_resp_o, (k == 0) ? 2'b00 : 2'b10);
            checkOutput("t5_r_last", r_last_o, (k == 2) ? 1 : 0);
            applyStimulus(1);
        end
        rx_valid_i = 0; r_ready_i = 0; rx_error_i = 0; rx_last_i = 0;

        // Overlapping windows 1 and 3, then reset in the middle of RD_DATA
        ar_valid_i = 1; ar_addr_i = 32'h0001_8000; ar_len_i = 3; ar_id_i = 8;
        applyStimulus(1); ar_valid_i = 0; #1;
        checkOutput("t6_trans_cs_overlap", trans_cs_o, 4'b0010);
        checkOutput("t6_trans_burst", trans_burst_o, 4);
        trans_ready_i = 1;
        applyStimulus(1); trans_ready_i = 0; rx_valid_i = 1; r_ready_i = 1; rx_data_i = 16'h7777; #1;
        checkOutput("t6_r_valid", r_valid_o, 1);
        checkOutput("t6_r_last", r_last_o, 0);
        applyStimulus(1); rst_ni = 0; #1;
        checkOutput("t6_rst_r_valid", r_valid_o, 0);
        checkOutput("t6_rst_rx_ready", rx_ready_o, 0);
        checkOutput("t6_rst_trans_cs", trans_cs_o, 0);
        checkOutput("t6_rst_trans_burst", trans_burst_o, 0);
        checkOutput("t6_rst_trans_valid", trans_valid_o, 0);
        checkOutput("t6_rst_r_id", r_id_o, 0);
        applyStimulus(1); rst_ni = 1; rx_valid_i = 0; r_ready_i = 0;
        ar_valid_i = 1; ar_addr_i = 32'h8002_0000; ar_len_i = 0; ar_id_i = 2; #1;
        checkOutput("t6_ar_ready_idle", ar_ready_o, 1);
        applyStimulus(1); ar_valid_i = 0; #1;
        checkOutput("t6_trans_cs_w3", trans_cs_o, 4'b1000);
        checkOutput("t6_trans_space", trans_address_space_o, 1);
        checkOutput("t6_trans_addr", trans_address_o, 32'h8002_0000);
        trans_ready_i = 1;
        applyStimulus(1); trans_ready_i = 0; rx_valid_i = 1; r_ready_i = 1; #1;
        checkOutput("t6_r_last_len0", r_last_o, 1);
        applyStimulus(1); rx_valid_i = 0; r_ready_i = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
